rv32_reg_file: RTL and testbench

//   32 x 32-bit integer register file (x0..x31) for the RV32I single-cycle core.
//   Two asynchronous read ports feed the ALU operands (rs1/rs2).
//   One synchronous write port is driven by the write-back stage (rd).
//   x0 is hardwired to zero.

---
 rtl/rv32_reg_file.sv | 37 +++
 tb/tb_rv32_reg_file.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rv32_reg_file.sv
// RV32I integer register file (x0..x31, x0 hardwired to zero); two combinational read ports, one write port.
// Reads are zero latency, writes land on the rising clk edge; no backpressure, every write is accepted.
module rv32_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rg_wrt_en,
    input  logic [ADDR_W-1:0] rg_wrt_dest,
    input  logic [DATA_W-1:0] rg_wrt_data,
    input  logic [ADDR_W-1:0] rg_rd_addr1,
    input  logic [ADDR_W-1:0] rg_rd_addr2,
    output logic [DATA_W-1:0] rg_rd_data1,
    output logic [DATA_W-1:0] rg_rd_data2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Reset wins over a write on the same edge; entry 0 is never written so it stays cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (rg_wrt_en && (rg_wrt_dest != '0)) begin
            regs[rg_wrt_dest] <= rg_wrt_data;
        end
    end

    // No write-to-read bypass: forwarding is handled outside the register file.
    assign rg_rd_data1 = (rg_rd_addr1 == '0) ? '0 : regs[rg_rd_addr1];
    assign rg_rd_data2 = (rg_rd_addr2 == '0) ? '0 : regs[rg_rd_addr2];

endmodule

// File: tb/tb_rv32_reg_file.sv
// Randomized scoreboard bench for rv32_reg_file against an array model of the architectural registers.
module tb_rv32_reg_file;

    logic        clk;
    logic        rst;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic [4:0]  rg_rd_addr1;
    logic [4:0]  rg_rd_addr2;
    logic [31:0] rg_rd_data1;
    logic [31:0] rg_rd_data2;

    rv32_reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_dest (rg_wrt_dest),
        .rg_wrt_data (rg_wrt_data),
        .rg_rd_addr1 (rg_rd_addr1),
        .rg_rd_addr2 (rg_rd_addr2),
        .rg_rd_data1 (rg_rd_data1),
        .rg_rd_data2 (rg_rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] e1;
        logic [31:0] e2;
        int          id;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [32];
    bit          chk_vld;
    int          checks;
    int          errors;
    int          txn_id;

    // Monitor: reads are sampled mid-cycle, after the stimulus settled and before the next edge.
    always @(negedge clk) begin
        if (chk_vld) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: read presented with no expected entry");
            end else begin
                e = exp_q.pop_front();
                if (rg_rd_data1 !== e.e1) begin
                    errors++;
                    $display("FAIL rd1 txn %0d addr %0d: got %h expected %h", e.id, rg_rd_addr1, rg_rd_data1, e.e1);
                end
                checks++;
                if (rg_rd_data2 !== e.e2) begin
                    errors++;
                    $display("FAIL rd2 txn %0d addr %0d: got %h expected %h", e.id, rg_rd_addr2, rg_rd_data2, e.e2);
                end
            end
        end
    end

    // One clock cycle of stimulus. Expected read data comes from the model as it stands
    // before this cycle's edge; the model is updated afterwards to reflect that edge.
    task automatic cycle(input logic r, input logic en, input logic [4:0] dest,
                         input logic [31:0] data, input logic [4:0] a1,
                         input logic [4:0] a2, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        rg_wrt_en   = en;
        rg_wrt_dest = dest;
        rg_wrt_data = data;
        rg_rd_addr1 = a1;
        rg_rd_addr2 = a2;
        if (chk) begin
            e.e1 = model[a1];
            e.e2 = model[a2];
            e.id = txn_id;
            exp_q.push_back(e);
        end
        chk_vld = chk;
        txn_id++;
        if (!r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (en && dest != 5'd0) begin
            model[dest] = data;
        end
    endtask

    initial begin
        logic [4:0]  rd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] wd;
        checks      = 0;
        errors      = 0;
        txn_id      = 0;
        chk_vld     = 1'b0;
        rst         = 1'b0;
        rg_wrt_en   = 1'b0;
        rg_wrt_dest = 5'd0;
        rg_wrt_data = 32'h0;
        rg_rd_addr1 = 5'd0;
        rg_rd_addr2 = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset, then every address on both ports reads zero.
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            cycle(1'b1, 1'b0, 5'd0, 32'h0, ra1, ra2, 1'b1);
        end

        // Basic write/read, x0 protection, enable gating.
        cycle(1'b1, 1'b1, 5'd4, 32'h12345678, 5'd4, 5'd1, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'h0,        5'd4, 5'd1, 1'b1);
        cycle(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1);
        cycle(1'b1, 1'b0, 5'd7, 32'hDEADBEEF, 5'd4, 5'd7, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'h0,        5'd4, 5'd7, 1'b1);
        cycle(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 5'd4, 5'd7, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'h0,        5'd4, 5'd7, 1'b1);

        // Read of the register being written shows the old value until the edge.
        cycle(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b1);

        // Reset beats a simultaneous write.
        cycle(1'b0, 1'b1, 5'd5, 32'h00000001, 5'd4, 5'd5, 1'b1);
        cycle(1'b1, 1'b0, 5'd0, 32'h0,        5'd4, 5'd5, 1'b1);

        // Fill x1..x31 with unique values, then read all back.
        for (int i = 1; i < 32; i++) begin
            rd = 5'(i);
            cycle(1'b1, 1'b1, rd, i * 32'h01010101, 5'd0, 5'd0, 1'b1);
        end
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'((i + 13) % 32);
            cycle(1'b1, 1'b0, 5'd0, 32'h0, ra1, ra2, 1'b1);
        end

        // Randomized traffic with occasional resets and same-address collisions.
        for (int n = 0; n < 1500; n++) begin
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), rd, wd, ra1, ra2, 1'b1);
        end

        @(posedge clk);
        #1;
        chk_vld   = 1'b0;
        rg_wrt_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
